serial_add_ctrl: RTL
====================

// Module: serial_add_ctrl
// PURPOSE
//   Bit-serial add/subtract sequencer around a single 1-bit full adder cell
//   (x = a^b^c, y = majority(a,b,c)).
//   - Accepts two WIDTH-bit operands and feeds them to the cell LSB-first, one bit per clock.
//   - Carries the cell's y output between bits in a carry flip-flop.
//   - Assembles the WIDTH-bit result and flags.
//   - Gives the datapath a start/busy/done handshake, so one cell serves full-word arithmetic.
// PARAMETERS
//   WIDTH    8   operand/result width in bits; legal range 2..32
//   CNT_W    $clog2(WIDTH)  bit-counter width (derived, do not override)
// PORTS
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous, active-high reset
//   start    in   1      request; sampled only in IDLE
//   op_sub   in   1      0 = a+b, 1 = a-b; sampled with start
//   a_in     in   WIDTH  operand A; sampled with start
//   b_in     in   WIDTH  operand B; sampled with start
//   busy     out  1      1 while state != IDLE
//   done     out  1      one-cycle pulse: result/flags valid
//   sum_out  out  WIDTH  result; held until next completion
//   cout     out  1      carry out of MSB (for sub: 1 = no borrow, a >= b unsigned)
//   ovf      out  1      signed overflow = carry into MSB ^ carry out of MSB
// BEHAVIOUR
//   - rst=1 at any time (incl. mid-operation) resets immediately:
//     state=IDLE, busy=0, done=0, sum_out=0, cout=0, ovf=0, internal shift regs/counter/carry FF = 0.
//     Any in-flight operation is aborted with no done.
//   - States:
//     - IDLE: start=1 at edge E0 loads the A shift reg with a_in and the B shift reg with
//       (op_sub ? ~b_in : b_in); carry FF=op_sub, count=0, -> RUN.
//     - RUN: each edge feeds A[0], B[0], carry FF to the cell. Cell x shifts into the result
//       reg from the MSB side; carry FF <= y; A,B shift right; count++.
//       - At count==WIDTH-2, also capture the carry FF as the carry-into-MSB for ovf.
//       - On the edge where count==WIDTH-1 (the WIDTH-th RUN edge, EW): -> DONE.
//     - DONE: done=1 for exactly this cycle; -> IDLE on next edge.
//       - sum_out/cout/ovf are registered on edge EW, valid from the DONE cycle and stable
//         until the next DONE.
//   - Latency: done high in the cycle after edge E(WIDTH+1)-1, i.e. WIDTH+1 clocks after
//     the start edge. Throughput: one op per WIDTH+2 clocks.
//   - start while busy (RUN or DONE) is ignored, not queued; operands are not re-sampled.
//   - start asserted in the first IDLE cycle after DONE is accepted normally (back-to-back).
//   - Arithmetic is modulo 2^WIDTH; no saturation. a_in/b_in may change freely once start is accepted.
//   - busy=0 and done=0 in IDLE; done and busy both 1 in DONE.
// TESTING
//   - WIDTH=8, add 0x5A+0x3C
//     -> done exactly 9 clks after start edge; sum_out=0x96, cout=0, ovf=1.
//   - Add 0xFF+0x01 -> sum_out=0x00, cout=1, ovf=0; 0x7F+0x01 -> 0x80, cout=0, ovf=1.
//   - Sub 0x10-0x20 -> sum_out=0xF0, cout=0, ovf=0; sub 0x80-0x01 -> 0x7F, cout=1, ovf=1.
//   - Pulse start with new operands during RUN and during DONE
//     -> ignored; first result unchanged, single done pulse.
//   - Assert rst 4 clks into an op
//     -> all outputs 0 immediately, no done; a fresh op afterwards completes correctly.
//   - Back-to-back: start held high continuously with fixed operands
//     -> done every 10 clks, sum_out stable between pulses.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell is reused LSB-first
// over WIDTH clocks, with a carry flip-flop between bits and a start/busy/done handshake.
module serial_add_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cmsb;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_done;

  logic             w_x;
  logic             w_y;
  logic             w_last;
  logic             w_pre_last;

  assign w_x        = fa_sum(r_a[0], r_b[0], r_carry);
  assign w_y        = fa_carry(r_a[0], r_b[0], r_carry);
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_pre_last = (r_cnt == CNT_W'(WIDTH - 2));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand shift registers, carry FF, bit counter and result assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_res   <= {WIDTH{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
      r_carry <= 1'b0;
      r_cmsb  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
            r_a     <= a_in;
            r_b     <= op_sub ? ~b_in : b_in;
            r_carry <= op_sub;
            r_cnt   <= {CNT_W{1'b0}};
          end else begin
            r_a     <= r_a;
            r_b     <= r_b;
            r_carry <= r_carry;
            r_cnt   <= r_cnt;
          end
        end
        S_RUN: begin
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_res   <= {w_x, r_res[WIDTH-1:1]};
          r_carry <= w_y;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_pre_last) begin
            r_cmsb <= w_y;
          end else begin
            r_cmsb <= r_cmsb;
          end
        end
        S_DONE: begin
          r_cnt <= r_cnt;
        end
        default: begin
          r_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Result/flag output registers, updated on the final RUN edge only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum  <= {WIDTH{1'b0}};
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if ((r_state == S_RUN) && w_last) begin
        r_sum  <= {w_x, r_res[WIDTH-1:1]};
        r_cout <= w_y;
        r_ovf  <= r_cmsb ^ w_y;
        r_done <= 1'b1;
      end else begin
        r_sum  <= r_sum;
        r_cout <= r_cout;
        r_ovf  <= r_ovf;
        r_done <= 1'b0;
      end
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign sum_out = r_sum;
  assign cout    = r_cout;
  assign ovf     = r_ovf;

endmodule
